gs_ports: RTL and testbench

- NGS-side Z80 I/O port block: the local-CPU end of the ZX↔GS mailbox.
- Decodes NGS Z80 I/O cycles and serves reads of the ZX command register, ZX data register and status.
- Latches the outbound data byte and issues one-cycle data_bit/command_bit write strobes to the zxbus block.
- Holds the memory page register and four volume registers.

---
 rtl/gs_ports_pkg.sv | 33 +++
 rtl/gs_int_gen.sv | 27 ++
 rtl/gs_ports.sv | 175 +++++++++++++++++
 tb/tb_gs_ports.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_ports_pkg.sv
// Shared constants and types for the NGS-side Z80 port block (gs_ports).
package gs_ports_pkg;

  localparam int VOL_W   = 6;
  localparam int NUM_VOL = 4;

  localparam logic [3:0] PORT_MPAG    = 4'h0;
  localparam logic [3:0] PORT_ZXCMD   = 4'h1;
  localparam logic [3:0] PORT_ZXDATRD = 4'h2;
  localparam logic [3:0] PORT_ZXDATWR = 4'h3;
  localparam logic [3:0] PORT_ZXSTAT  = 4'h4;
  localparam logic [3:0] PORT_CLRCBIT = 4'h5;
  localparam logic [3:0] PORT_VOL1    = 4'h6;
  localparam logic [3:0] PORT_VOL2    = 4'h7;
  localparam logic [3:0] PORT_VOL3    = 4'h8;
  localparam logic [3:0] PORT_VOL4    = 4'h9;
  localparam logic [3:0] PORT_DBITSET = 4'hA;

  // Write cycle as captured while iowr is active.
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } io_req_t;

  // Flag-load strobes toward zxbus.
  typedef struct packed {
    logic data_wr;
    logic data_in;
    logic cmd_wr;
    logic cmd_in;
  } strobe_t;

endpackage

// File: rtl/gs_int_gen.sv
// Periodic Z80 interrupt: int_n low for INT_LEN clocks out of every INT_DIV.
module gs_int_gen #(
  parameter int INT_DIV = 320,
  parameter int INT_LEN = 32
) (
  input  logic cpu_clock,
  input  logic rst_n,
  output logic int_n
);

  localparam int CW = $clog2(INT_DIV);

  logic [CW-1:0] cnt;

  // int_n is registered from the current count, so the first low pulse
  // appears right after the first clock following reset release.
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      int_n <= 1'b1;
    end else begin
      cnt   <= (cnt == CW'(INT_DIV - 1)) ? '0 : cnt + 1'b1;
      int_n <= !(cnt < CW'(INT_LEN));
    end
  end

endmodule

// File: rtl/gs_ports.sv
// NGS Z80 I/O port block: mailbox reads, outbound data latch, flag strobes,
// page and volume registers. Define GS_INT_EN to add the periodic int_n.
module gs_ports
  import gs_ports_pkg::*;
#(
  parameter int INT_DIV = 320,
  parameter int INT_LEN = 32
) (
  input  logic             cpu_clock,
  input  logic             rst_n,
  input  logic [7:0]       a,
  input  logic             iorq_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             m1_n,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             dout_ena,
  input  logic [7:0]       zx_cmd,
  input  logic [7:0]       zx_data_rx,
  output logic [7:0]       zx_data_tx,
  input  logic             data_bit,
  input  logic             command_bit,
  output logic             data_bit_in,
  output logic             command_bit_in,
  output logic             data_bit_wr,
  output logic             command_bit_wr,
  output logic [VOL_W-1:0] mpag,
  output logic [VOL_W-1:0] vol0,
  output logic [VOL_W-1:0] vol1,
  output logic [VOL_W-1:0] vol2,
  output logic [VOL_W-1:0] vol3
`ifdef GS_INT_EN
  ,
  output logic             int_n
`endif
);

  if (INT_LEN >= INT_DIV) begin : g_bad_int
    $error("gs_ports: INT_LEN must be below INT_DIV");
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^a[7:4];

  logic iord, iowr, iord_q, iowr_q;
  logic rd_arm, wr_arm, rd_fire, wr_fire;
  logic [3:0] rd_addr;
  io_req_t    wr_req;
  strobe_t    stb_nxt, stb_q;
  logic [NUM_VOL-1:0][VOL_W-1:0] vol_q;

  // Interrupt-acknowledge (iorq+m1 low) never qualifies.
  assign iord = ~iorq_n & ~rd_n & m1_n;
  assign iowr = ~iorq_n & ~wr_n & m1_n;

  assign rd_fire = iord_q & ~iord & rd_arm;
  assign wr_fire = iowr_q & ~iowr & wr_arm;

  // Delayed qualifiers reset high: a cycle already running at reset release
  // shows no rising edge, so it is never armed.
  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      iord_q  <= 1'b1;
      iowr_q  <= 1'b1;
      rd_arm  <= 1'b0;
      wr_arm  <= 1'b0;
      rd_addr <= '0;
      wr_req  <= '0;
    end else begin
      iord_q <= iord;
      iowr_q <= iowr;

      if (iowr & ~iowr_q) begin
        wr_arm      <= 1'b1;
        wr_req.addr <= a[3:0];
        wr_req.data <= din;
      end else if (iowr) begin
        wr_req.data <= din;
      end else if (wr_fire) begin
        wr_arm <= 1'b0;
      end

      if (iord & ~iord_q) begin
        rd_arm  <= 1'b1;
        rd_addr <= a[3:0];
      end else if (rd_fire) begin
        rd_arm <= 1'b0;
      end
    end
  end

  // Trailing-edge side effects; a Z80 cycle is either read or write,
  // so at most one strobe fires.
  always_comb begin
    stb_nxt = '0;
    if (wr_fire) begin
      case (wr_req.addr)
        PORT_ZXDATWR: begin stb_nxt.data_wr = 1'b1; stb_nxt.data_in = 1'b1; end
        PORT_CLRCBIT: stb_nxt.cmd_wr = 1'b1;
        PORT_DBITSET: begin stb_nxt.data_wr = 1'b1; stb_nxt.data_in = wr_req.data[7]; end
        default: ;
      endcase
    end else if (rd_fire) begin
      case (rd_addr)
        PORT_ZXDATRD: stb_nxt.data_wr = 1'b1;
        PORT_CLRCBIT: stb_nxt.cmd_wr  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      stb_q      <= '0;
      mpag       <= '0;
      zx_data_tx <= '0;
    end else begin
      stb_q <= stb_nxt;
      if (wr_fire && wr_req.addr == PORT_MPAG)    mpag       <= wr_req.data[VOL_W-1:0];
      if (wr_fire && wr_req.addr == PORT_ZXDATWR) zx_data_tx <= wr_req.data;
    end
  end

  for (genvar g = 0; g < NUM_VOL; g++) begin : g_vol
    always_ff @(posedge cpu_clock or negedge rst_n) begin
      if (!rst_n)
        vol_q[g] <= '0;
      else if (wr_fire && wr_req.addr == PORT_VOL1 + 4'(g))
        vol_q[g] <= wr_req.data[VOL_W-1:0];
    end
  end

  assign vol0 = vol_q[0];
  assign vol1 = vol_q[1];
  assign vol2 = vol_q[2];
  assign vol3 = vol_q[3];

  assign data_bit_wr    = stb_q.data_wr;
  assign data_bit_in    = stb_q.data_in;
  assign command_bit_wr = stb_q.cmd_wr;
  assign command_bit_in = stb_q.cmd_in;

  // Read mux follows the live bus so data is valid for the whole rd_n low.
  always_comb begin
    dout     = 8'h00;
    dout_ena = 1'b0;
    if (iord) begin
      dout_ena = 1'b1;
      case (a[3:0])
        PORT_MPAG:    dout = {2'b00, mpag};
        PORT_ZXCMD:   dout = zx_cmd;
        PORT_ZXDATRD: dout = zx_data_rx;
        PORT_ZXSTAT:  dout = {data_bit, 6'b000000, command_bit};
        PORT_VOL1:    dout = {2'b00, vol_q[0]};
        PORT_VOL2:    dout = {2'b00, vol_q[1]};
        PORT_VOL3:    dout = {2'b00, vol_q[2]};
        PORT_VOL4:    dout = {2'b00, vol_q[3]};
        default:      dout_ena = 1'b0;
      endcase
    end
  end

`ifdef GS_INT_EN
  gs_int_gen #(
    .INT_DIV (INT_DIV),
    .INT_LEN (INT_LEN)
  ) u_int_gen (
    .cpu_clock (cpu_clock),
    .rst_n     (rst_n),
    .int_n     (int_n)
  );
`endif

endmodule

// File: tb/tb_gs_ports.sv
// Self-checking bench for gs_ports: directed steps plus random I/O cycles
// against a register-level reference model.
module tb_gs_ports;

  logic       cpu_clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic       iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_ena;
  logic [7:0] zx_cmd = 8'h00, zx_data_rx = 8'h00;
  logic [7:0] zx_data_tx;
  logic       data_bit = 1'b0, command_bit = 1'b0;
  logic       data_bit_in, command_bit_in, data_bit_wr, command_bit_wr;
  logic [5:0] mpag, vol0, vol1, vol2, vol3;
`ifdef GS_INT_EN
  logic       int_n;
`endif

  gs_ports #(.INT_DIV(320), .INT_LEN(32)) dut (
    .cpu_clock (cpu_clock), .rst_n (rst_n), .a (a),
    .iorq_n (iorq_n), .rd_n (rd_n), .wr_n (wr_n), .m1_n (m1_n),
    .din (din), .dout (dout), .dout_ena (dout_ena),
    .zx_cmd (zx_cmd), .zx_data_rx (zx_data_rx), .zx_data_tx (zx_data_tx),
    .data_bit (data_bit), .command_bit (command_bit),
    .data_bit_in (data_bit_in), .command_bit_in (command_bit_in),
    .data_bit_wr (data_bit_wr), .command_bit_wr (command_bit_wr),
    .mpag (mpag), .vol0 (vol0), .vol1 (vol1), .vol2 (vol2), .vol3 (vol3)
`ifdef GS_INT_EN
    , .int_n (int_n)
`endif
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [5:0] m_mpag;
  logic [5:0] m_vol [4];
  logic [7:0] m_tx;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic model_reset();
    m_mpag = '0;
    m_tx   = '0;
    for (int i = 0; i < 4; i++) m_vol[i] = '0;
  endtask

  // Strobe vector {data_bit_wr, data_bit_in, command_bit_wr, command_bit_in}
  function automatic logic [3:0] stb_obs();
    return {data_bit_wr, data_bit_in, command_bit_wr, command_bit_in};
  endfunction

  // Expected strobe one clock after the end of a cycle on port p.
  function automatic logic [3:0] stb_exp(input bit is_wr, input int p, input logic [7:0] d);
    if (is_wr) begin
      if (p == 3)  return 4'b1100;
      if (p == 5)  return 4'b0010;
      if (p == 10) return {1'b1, d[7], 2'b00};
    end else begin
      if (p == 2)  return 4'b1000;
      if (p == 5)  return 4'b0010;
    end
    return 4'b0000;
  endfunction

  // Expected {dout_ena, dout} for a read of port p.
  function automatic logic [8:0] rd_exp(input int p);
    if (p == 0) return {1'b1, 2'b00, m_mpag};
    if (p == 1) return {1'b1, zx_cmd};
    if (p == 2) return {1'b1, zx_data_rx};
    if (p == 4) return {1'b1, data_bit, 6'b0, command_bit};
    if (p >= 6 && p <= 9) return {1'b1, 2'b00, m_vol[p-6]};
    return 9'h000;
  endfunction

  task automatic model_write(input int p, input logic [7:0] d);
    if (p == 0) m_mpag = d[5:0];
    if (p == 3) m_tx = d;
    if (p >= 6 && p <= 9) m_vol[p-6] = d[5:0];
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".mpag"}, 16'(mpag), 16'(m_mpag));
    check({tag, ".tx"},   16'(zx_data_tx), 16'(m_tx));
    check({tag, ".vols"}, 16'({vol3[3:0], vol2[3:0], vol1[3:0], vol0[3:0]}),
          16'({m_vol[3][3:0], m_vol[2][3:0], m_vol[1][3:0], m_vol[0][3:0]}));
    check({tag, ".volhi"}, 16'({vol3[5:4], vol2[5:4], vol1[5:4], vol0[5:4]}),
          16'({m_vol[3][5:4], m_vol[2][5:4], m_vol[1][5:4], m_vol[0][5:4]}));
  endtask

  task automatic io_write(input string tag, input logic [7:0] addr, input logic [7:0] d);
    int p = int'(addr[3:0]);
    a = addr; din = 8'($urandom); m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    check({tag, ".stb_busy"}, 16'(stb_obs()), 16'h0);
    din = d;
    tick();
    tick();
    iorq_n = 1'b1; wr_n = 1'b1; din = 8'($urandom);
    tick();
    model_write(p, d);
    check({tag, ".stb"}, 16'(stb_obs()), 16'(stb_exp(1'b1, p, d)));
    check_regs(tag);
    tick();
    check({tag, ".stb_after"}, 16'(stb_obs()), 16'h0);
  endtask

  task automatic io_read(input string tag, input logic [7:0] addr);
    int p = int'(addr[3:0]);
    a = addr; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check({tag, ".rd"}, 16'({dout_ena, dout}), 16'(rd_exp(p)));
    tick();
    tick();
    check({tag, ".rd_late"}, 16'({dout_ena, dout}), 16'(rd_exp(p)));
    check({tag, ".stb_busy"}, 16'(stb_obs()), 16'h0);
    iorq_n = 1'b1; rd_n = 1'b1;
    #1;
    check({tag, ".rd_idle"}, 16'({dout_ena, dout}), 16'h0);
    tick();
    check({tag, ".stb"}, 16'(stb_obs()), 16'(stb_exp(1'b0, p, 8'h00)));
    tick();
    check({tag, ".stb_after"}, 16'(stb_obs()), 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge cpu_clock);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    check("reset.stb", 16'(stb_obs()), 16'h0);
    check("reset.rd", 16'({dout_ena, dout}), 16'h0);
    check_regs("reset");
`ifdef GS_INT_EN
`else
    check("reset.int_n", 16'(dout_ena), 16'h0);
`endif

    // Directed steps
    io_write("out3", 8'h03, 8'h5A);
    zx_data_rx = 8'hC3;
    io_read("in2", 8'h02);
    data_bit = 1'b1; command_bit = 1'b1;
    io_read("in4", 8'h04);
    io_write("out5", 8'h05, 8'h33);
    io_read("in5", 8'h05);
    for (int i = 6; i <= 9; i++) io_write("outvol", 8'(i), 8'hFF);
    for (int i = 6; i <= 9; i++) io_read("invol", 8'(i));
    io_write("outF7", 8'hF7, 8'h15);
    io_write("outA_hi", 8'h0A, 8'h80);
    io_write("outA_lo", 8'h0A, 8'h7F);
    io_write("out0", 8'h40, 8'hEA);
    io_read("in0", 8'h30);
    io_read("inB", 8'h0B);
    io_write("outE", 8'h0E, 8'hFF);

    // Reset released while a port-3 write is in progress
    rst_n = 1'b0;
    model_reset();
    a = 8'h03; din = 8'h77; iorq_n = 1'b0; wr_n = 1'b0; m1_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
    check("rstmid.stb", 16'(stb_obs()), 16'h0);
    tick();
    check("rstmid.stb2", 16'(stb_obs()), 16'h0);
    check_regs("rstmid");

    // Interrupt acknowledge cycles are ignored
    a = 8'h02; din = 8'h99; iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
    #1;
    check("inta.rd", 16'({dout_ena, dout}), 16'h0);
    tick();
    rd_n = 1'b1; wr_n = 1'b0; a = 8'h03;
    tick();
    tick();
    iorq_n = 1'b1; m1_n = 1'b1; wr_n = 1'b1;
    tick();
    check("inta.stb", 16'(stb_obs()), 16'h0);
    tick();
    check("inta.stb2", 16'(stb_obs()), 16'h0);
    check_regs("inta");

    // Random cycles against the model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] addr, d;
      addr = 8'($urandom);
      d = 8'($urandom);
      zx_cmd = 8'($urandom);
      zx_data_rx = 8'($urandom);
      data_bit = 1'($urandom);
      command_bit = 1'($urandom);
      if ($urandom_range(1, 0) == 1) io_write("rnd_wr", addr, d);
      else io_read("rnd_rd", addr);
    end

`ifdef GS_INT_EN
    // Interrupt timing over three periods from reset release
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 960; k++) begin
      tick();
      check("int_n", 16'(int_n), ((k - 1) % 320 < 32) ? 16'h0 : 16'h1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
